// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state encoding and default counter width for pulse_meter.
package pulse_pkg;
    localparam int DEFAULT_WIDTH = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus history flop with rise/fall detection.
// Ports: clock (rising edge), clear (async active-low), in (async input),
//        s (synchronized level), rise/fall (one-cycle edge strobes).
module sync_edge (
    input  logic clock,
    input  logic clear,
    input  logic in,
    output logic s,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, sd_q;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
            sd_q <= s2_q;
        end
    end
    assign s    = s2_q;
    assign rise = s2_q & ~sd_q;
    assign fall = ~s2_q & sd_q;
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and rise-to-rise period of an async pulse train.
// Ports: clock, clear (async active-low), signal (async pulse input),
//        valid (one-cycle strobe), high_width, period (WIDTH+1 bits),
//        pulse_count (wrapping), overflow (sticky), timeout (one-cycle strobe).
// Build option: define PULSE_METER_FILTER_EN to drop highs shorter than MIN_HIGH.
module pulse_meter
    import pulse_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = 8,
    parameter int MIN_HIGH    = 2
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   signal,
    output logic                   valid,
    output logic [WIDTH-1:0]       high_width,
    output logic [WIDTH:0]         period,
    output logic [COUNT_WIDTH-1:0] pulse_count,
    output logic                   overflow,
    output logic                   timeout
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic s, rise, fall, glitch;
    state_e state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, hw_q, hw_d;
    logic [WIDTH:0] per_q, per_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, ovf_q, ovf_d, to_q, to_d;

    sync_edge u_sync (
        .clock(clock),
        .clear(clear),
        .in   (signal),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

`ifdef PULSE_METER_FILTER_EN
    assign glitch = hi_q < WIDTH'(MIN_HIGH);
`else
    logic unused_min_high;
    assign unused_min_high = (MIN_HIGH != 0);
    assign glitch = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hw_d    = hw_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hi_d    = ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = glitch ? IDLE : LOW;
                    hi_d    = glitch ? '0 : hi_q;
                    lo_d    = glitch ? '0 : ONE;
                end else if (s && hi_q != MAX) begin
                    hi_d = hi_q + ONE;
                end
            end
            LOW: begin
                // A rise wins over a pending timeout, so a saturated low still completes.
                if (rise) begin
                    valid_d = 1'b1;
                    hw_d    = hi_q;
                    per_d   = {1'b0, hi_q} + {1'b0, lo_q};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HIGH;
                    hi_d    = ONE;
                    lo_d    = '0;
                end else if (lo_q == MAX) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    hi_d    = '0;
                    lo_d    = '0;
                end else if (!s) begin
                    lo_d = lo_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Either counter landing on its ceiling marks the sticky overflow.
        ovf_d = ovf_q | (hi_d == MAX) | (lo_d == MAX);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            hw_q    <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hw_q    <= hw_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    assign valid       = valid_q;
    assign high_width  = hw_q;
    assign period      = per_q;
    assign pulse_count = cnt_q;
    assign overflow    = ovf_q;
    assign timeout     = to_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed table-driven bench for pulse_meter (16-bit and 4-bit instances).
module tb_pulse_meter;
    typedef struct {
        int hw;
        int per;
        int cnt;
        int cyc;
    } meas_t;

    typedef struct {
        int h;
        int l;
        int hw;
        int per;
    } vec_t;

    logic clock = 1'b0;
    logic clear_a = 1'b1, clear_b = 1'b1;
    logic sig_a = 1'b0, sig_b = 1'b0;

    logic        va, ovf_a, to_a;
    logic [15:0] hw_a;
    logic [16:0] per_a;
    logic [7:0]  cnt_a;
    logic        vb, ovf_b, to_b;
    logic [3:0]  hw_b;
    logic [4:0]  per_b;
    logic [1:0]  cnt_b;

    int checks = 0, failures = 0, cyc = 0;
    int to_cnt_b = 0, to_cyc_b = 0, to_cnt_a = 0;
    meas_t qa[$], qb[$];
    vec_t tv[6];

    pulse_meter #(.WIDTH(16), .COUNT_WIDTH(8), .MIN_HIGH(2)) ua (
        .clock(clock), .clear(clear_a), .signal(sig_a), .valid(va),
        .high_width(hw_a), .period(per_a), .pulse_count(cnt_a),
        .overflow(ovf_a), .timeout(to_a)
    );

    pulse_meter #(.WIDTH(4), .COUNT_WIDTH(2), .MIN_HIGH(2)) ub (
        .clock(clock), .clear(clear_b), .signal(sig_b), .valid(vb),
        .high_width(hw_b), .period(per_b), .pulse_count(cnt_b),
        .overflow(ovf_b), .timeout(to_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        meas_t m;
        if (va) begin
            m.hw = int'(hw_a); m.per = int'(per_a); m.cnt = int'(cnt_a); m.cyc = cyc;
            qa.push_back(m);
        end
        if (vb) begin
            m.hw = int'(hw_b); m.per = int'(per_b); m.cnt = int'(cnt_b); m.cyc = cyc;
            qb.push_back(m);
        end
        if (to_b) begin
            to_cnt_b++;
            to_cyc_b = cyc;
        end
        if (to_a) to_cnt_a++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input int h, input int l);
        sig_a = 1'b1; tick(h);
        sig_a = 1'b0; tick(l);
    endtask

    task automatic drive_b(input int h, input int l);
        sig_b = 1'b1; tick(h);
        sig_b = 1'b0; tick(l);
    endtask

    task automatic reset_a();
        sig_a = 1'b0; clear_a = 1'b0; tick(2);
        qa.delete(); clear_a = 1'b1; tick(2);
    endtask

    task automatic reset_b();
        sig_b = 1'b0; clear_b = 1'b0; tick(2);
        qb.delete(); to_cnt_b = 0; clear_b = 1'b1; tick(2);
    endtask

    initial begin
        int n;
        int e_hw[3], e_per[3];
        tv[0] = '{3, 5, 3, 8};
        tv[1] = '{3, 5, 3, 8};
        tv[2] = '{3, 5, 3, 8};
        tv[3] = '{2, 1, 2, 3};
        tv[4] = '{7, 2, 7, 9};
        tv[5] = '{5, 11, 5, 16};

        #2 clear_a = 1'b0; clear_b = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, va}, 0);
        chk("rst_hw", {16'd0, hw_a}, 0);
        chk("rst_period", {15'd0, per_a}, 0);
        chk("rst_count", {24'd0, cnt_a}, 0);
        chk("rst_overflow", {31'd0, ovf_a}, 0);
        chk("rst_timeout", {31'd0, to_a}, 0);
        chk("rst_b_overflow", {31'd0, ovf_b}, 0);
        clear_a = 1'b1; clear_b = 1'b1;
        tick(2);

        foreach (tv[i]) drive_a(tv[i].h, tv[i].l);
        sig_a = 1'b1; tick(6);
        chk("tbl_nvalid", qa.size(), 6);
        foreach (tv[i]) begin
            if (i < qa.size()) begin
                chk($sformatf("tbl%0d_hw", i), qa[i].hw, tv[i].hw);
                chk($sformatf("tbl%0d_per", i), qa[i].per, tv[i].per);
                chk($sformatf("tbl%0d_cnt", i), qa[i].cnt, i + 1);
                if (i > 0 && i < 3) chk($sformatf("tbl%0d_gap", i), qa[i].cyc - qa[i-1].cyc, 8);
            end
        end
        chk("tbl_no_timeout", to_cnt_a, 0);

        sig_a = 1'b0; clear_a = 1'b0; tick(2);
        clear_a = 1'b1; tick(3);
        sig_a = 1'b1; tick(4);
        clear_a = 1'b0; #1;
        chk("clr_valid", {31'd0, va}, 0);
        chk("clr_hw", {16'd0, hw_a}, 0);
        chk("clr_period", {15'd0, per_a}, 0);
        chk("clr_count", {24'd0, cnt_a}, 0);
        sig_a = 1'b0; tick(2);
        qa.delete(); clear_a = 1'b1; tick(2);
        drive_a(3, 5); drive_a(3, 5);
        sig_a = 1'b1; tick(6);
        chk("clr_nvalid", qa.size(), 2);
        if (qa.size() == 2) begin
            chk("clr_m0_hw", qa[0].hw, 3);
            chk("clr_m0_per", qa[0].per, 8);
            chk("clr_m1_cnt", qa[1].cnt, 2);
        end

        reset_a();
        #3;
        for (int k = 0; k < 11; k++) begin
            sig_a = 1'b1; #40;
            sig_a = 1'b0; #40;
        end
        tick(6);
        chk("gen_nvalid", qa.size(), 10);
        foreach (qa[i]) begin
            chk($sformatf("gen%0d_hw", i), qa[i].hw, 4);
            chk($sformatf("gen%0d_per", i), qa[i].per, 8);
        end

        reset_a();
        drive_a(3, 5); drive_a(1, 5); drive_a(3, 5);
        sig_a = 1'b1; tick(6);
`ifdef PULSE_METER_FILTER_EN
        n = 2;
        e_hw = '{3, 3, 0}; e_per = '{8, 8, 0};
`else
        n = 3;
        e_hw = '{3, 1, 3}; e_per = '{8, 6, 8};
`endif
        chk("flt_nvalid", qa.size(), n);
        for (int i = 0; i < n && i < qa.size(); i++) begin
            chk($sformatf("flt%0d_hw", i), qa[i].hw, e_hw[i]);
            chk($sformatf("flt%0d_per", i), qa[i].per, e_per[i]);
            chk($sformatf("flt%0d_cnt", i), qa[i].cnt, i + 1);
        end

        reset_b();
        n = cyc;
        drive_b(3, 20);
        chk("to_count", to_cnt_b, 1);
        chk("to_cycle", to_cyc_b - n, 21);
        chk("to_nvalid", qb.size(), 0);
        chk("to_overflow", {31'd0, ovf_b}, 1);
        drive_b(2, 3);
        sig_b = 1'b1; tick(6);
        chk("idle_nvalid", qb.size(), 1);
        if (qb.size() == 1) begin
            chk("idle_hw", qb[0].hw, 2);
            chk("idle_per", qb[0].per, 5);
        end

        reset_b();
        chk("sat_ovf_cleared", {31'd0, ovf_b}, 0);
        drive_b(20, 2);
        sig_b = 1'b1; tick(6);
        chk("sat_nvalid", qb.size(), 1);
        if (qb.size() == 1) begin
            chk("sat_hw", qb[0].hw, 15);
            chk("sat_per", qb[0].per, 17);
        end
        chk("sat_overflow", {31'd0, ovf_b}, 1);

        reset_b();
        drive_b(2, 15);
        sig_b = 1'b1; tick(6);
        chk("race_nvalid", qb.size(), 1);
        if (qb.size() == 1) chk("race_per", qb[0].per, 17);
        chk("race_no_timeout", to_cnt_b, 0);
        chk("race_overflow", {31'd0, ovf_b}, 1);

        reset_b();
        repeat (5) drive_b(2, 2);
        sig_b = 1'b1; tick(6);
        chk("wrap_nvalid", qb.size(), 5);
        foreach (qb[i]) begin
            chk($sformatf("wrap%0d_cnt", i), qb[i].cnt, (i + 1) % 4);
            chk($sformatf("wrap%0d_per", i), qb[i].per, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
